// File: rtl/poly_eval_pkg.sv
// poly_eval_pkg: shared state codes, mux selects, ALU ops and control vector for poly_eval_core
package poly_eval_pkg;
  localparam int DEFAULT_WIDTH = 16;
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LDX  = 4'd1,
    MUL1 = 4'd2,
    ADD1 = 4'd3,
    MUL2 = 4'd4,
    ADD2 = 4'd5,
    DONE = 4'd6
  } state_t;
  localparam logic [1:0] M0_A = 2'd0, M0_H = 2'd1, M0_S = 2'd2, M0_ZERO = 2'd3;
  localparam logic [1:0] M1_X = 2'd0, M1_B = 2'd1, M1_C = 2'd2, M1_ZERO = 2'd3;
  localparam logic [1:0] M2_ALU = 2'd0, M2_ZERO = 2'd1;
  localparam logic OP_ADD = 1'b0, OP_MUL = 1'b1;
  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       lx;
    logic       lh;
    logic       ls;
    logic       h;
  } ctrl_t;
endpackage

// File: rtl/poly_eval_core_datapath.sv
// poly_eval_datapath: X/H/S registers, operand muxes and shared add/multiply ALU
//   ports: clk, rst (async high), a/b/c/x operands, ctrl vector in; result (S_REG) out;
//   ovf out only when POLY_OVF_EN is defined
module poly_eval_datapath
  import poly_eval_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] x,
  input  ctrl_t            ctrl,
  output logic [WIDTH-1:0] result
`ifdef POLY_OVF_EN
  ,
  output logic             ovf
`endif
);
`ifdef POLY_OVF_EN
  localparam int FW = 2 * WIDTH;
  logic ovf_q, ovf_d;
`else
  localparam int FW = WIDTH;
`endif
  logic [WIDTH-1:0] x_q, x_d, h_q, h_d, s_q, s_d, p, q, wr;
  logic [FW-1:0] full;
  always_comb begin
    p = ctrl.m0 == M0_A ? a : ctrl.m0 == M0_H ? h_q : ctrl.m0 == M0_S ? s_q : '0;
    q = ctrl.m1 == M1_X ? x_q : ctrl.m1 == M1_B ? b : ctrl.m1 == M1_C ? c : '0;
    full = ctrl.h == OP_MUL ? FW'(p) * FW'(q) : FW'(p) + FW'(q);
    wr = ctrl.m2 == M2_ZERO ? '0 : full[WIDTH-1:0];
    x_d = ctrl.lx ? x : x_q;
    h_d = ctrl.lh ? wr : h_q;
    s_d = ctrl.ls ? wr : s_q;
`ifdef POLY_OVF_EN
    ovf_d = ctrl.lx ? 1'b0
          : ovf_q | ((ctrl.lh | ctrl.ls) & (ctrl.m2 != M2_ZERO) & (|full[FW-1:WIDTH]));
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= '0;
      h_q <= '0;
      s_q <= '0;
`ifdef POLY_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      x_q <= x_d;
      h_q <= h_d;
      s_q <= s_d;
`ifdef POLY_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  assign result = s_q;
`ifdef POLY_OVF_EN
  assign ovf = ovf_q;
`endif
endmodule

// File: rtl/poly_eval_core.sv
// poly_eval_core: Horner evaluation of A*x^2+B*x+C with a control FSM over a shared-ALU datapath
//   ports: clk, rst (async high), w start pulse, a/b/c/x operands in; y state code,
//   result, done out; ovf out only when POLY_OVF_EN is defined
module poly_eval_core
  import poly_eval_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] x,
  output logic [3:0]       y,
  output logic [WIDTH-1:0] result,
  output logic             done
`ifdef POLY_OVF_EN
  ,
  output logic             ovf
`endif
);
  state_t state_q, state_d;
  ctrl_t ctrl;
  always_comb begin
    state_d = IDLE;
    ctrl = '0;
    case (state_q)
      IDLE: state_d = w ? LDX : IDLE;
      LDX: begin
        ctrl.lx = 1'b1;
        state_d = MUL1;
      end
      MUL1: begin
        ctrl = '{m0: M0_A, m1: M1_X, m2: M2_ALU, lx: 1'b0, lh: 1'b1, ls: 1'b0, h: OP_MUL};
        state_d = ADD1;
      end
      ADD1: begin
        ctrl = '{m0: M0_H, m1: M1_B, m2: M2_ALU, lx: 1'b0, lh: 1'b1, ls: 1'b0, h: OP_ADD};
        state_d = MUL2;
      end
      MUL2: begin
        ctrl = '{m0: M0_H, m1: M1_X, m2: M2_ALU, lx: 1'b0, lh: 1'b1, ls: 1'b0, h: OP_MUL};
        state_d = ADD2;
      end
      ADD2: begin
        ctrl = '{m0: M0_H, m1: M1_C, m2: M2_ALU, lx: 1'b0, lh: 1'b0, ls: 1'b1, h: OP_ADD};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  assign y = state_q;
  assign done = state_q == DONE;
  poly_eval_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .c(c),
    .x(x),
    .ctrl(ctrl),
    .result(result)
`ifdef POLY_OVF_EN
    ,
    .ovf(ovf)
`endif
  );
endmodule

// File: tb/tb_poly_eval_core.sv
// tb_poly_eval_core: directed and randomized self-checking bench for poly_eval_core
module tb_poly_eval_core;
  logic clk = 1'b0, rst = 1'b1, w = 1'b0;
  logic [15:0] a = '0, b = '0, c = '0, x = '0;
  logic [3:0] y;
  logic [15:0] result;
  logic done;
`ifdef POLY_OVF_EN
  logic ovf;
`endif
  int n_cmp = 0, n_bad = 0;

  poly_eval_core dut (
    .clk(clk),
    .rst(rst),
    .w(w),
    .a(a),
    .b(b),
    .c(c),
    .x(x),
    .y(y),
    .result(result),
    .done(done)
`ifdef POLY_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] poly(input longint pa, pb, pc, px);
    return 16'((pa * px * px + pb * px + pc) & 64'hFFFF);
  endfunction

  function automatic logic ovf_model(input longint pa, pb, pc, px);
    longint v;
    logic o;
    v = pa * px;       o = v > 65535; v &= 65535;
    v = v + pb;        o |= v > 65535; v &= 65535;
    v = v * px;        o |= v > 65535; v &= 65535;
    v = v + pc;        o |= v > 65535;
    return o;
  endfunction

  // Starts a run from IDLE, checks the state walk 1..6 then 0, done only in DONE,
  // and the result at DONE; wmask[s] is the level of w driven during state s.
  task automatic run(input logic [15:0] ia, ib, ic, ix, input logic [7:0] wmask);
    a = ia; b = ib; c = ic; x = ix;
    w = 1'b1;
    @(negedge clk);
    for (int s = 1; s <= 6; s++) begin
      chk("state", y, s);
      chk("done", done, s == 6);
      if (s == 6) begin
        chk("result", result, poly(ia, ib, ic, ix));
`ifdef POLY_OVF_EN
        chk("ovf", ovf, ovf_model(ia, ib, ic, ix));
`endif
      end
      w = wmask[s];
      @(negedge clk);
    end
    chk("state_back_idle", y, 0);
    chk("done_low_after", done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_y", y, 0);
      chk("rst_result", result, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
    end
    run(16'd11, 16'd10, 16'd0, 16'd1, 8'h00);
    run(16'd3, 16'd2, 16'd5, 16'd4, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("hold_result", result, 61);
      chk("hold_y", y, 0);
      @(negedge clk);
    end
    run(16'h0100, 16'd0, 16'd1, 16'h0100, 8'h00);
    chk("wrap_result", result, 1);
    run(16'd7, 16'd9, 16'd1234, 16'd0, 8'h00);
    chk("x0_gives_c", result, 1234);
    run(16'd5, 16'd6, 16'd7, 16'd8, 8'b0010_0100);
    for (int i = 0; i < 3; i++) begin
      chk("no_restart_y", y, 0);
      chk("no_restart_done", done, 0);
      @(negedge clk);
    end
    run(16'd2, 16'd3, 16'd4, 16'd5, 8'h7F);
    @(negedge clk);
    chk("held_w_restart", y, 1);
    w = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_run_idle", y, 0);
    chk("held_run_result", result, poly(2, 3, 4, 5));
    a = 16'd9; b = 16'd8; c = 16'd7; x = 16'd6;
    w = 1'b1;
    @(negedge clk);
    w = 1'b0;
    for (int i = 0; i < 10 && y != 4; i++) @(negedge clk);
    chk("reach_mul2", y, 4);
    rst = 1'b1;
    #1;
    chk("abort_y", y, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", y, 0);
    run(16'd9, 16'd8, 16'd7, 16'd6, 8'h00);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] ra, rb, rc, rx;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      rx = (i % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      if (i % 5 == 1) ra = '0;
      run(ra, rb, rc, rx, 8'h00);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
